spi_mosi_burst_tx: RTL

Parametrised SPI MOSI burst transmitter for the SSD1331 OLED path. It merges byte buffering and serialisation into one block. It latches up to N words with a per-word D/C flag in one cycle, then shifts them out back-to-back on o_MOSI under a single chip-select window. It adds selectable bit order, programmable inter-word gap, a busy/done handshake, and clamping of illegal counts. It sits between the OLED command sequencer and the pads.

---
 rtl/spi_burst_pkg.sv | 22 ++
 rtl/spi_word_serializer.sv | 34 +++
 rtl/spi_mosi_burst_tx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_burst_pkg.sv
// Shared definitions for the SPI MOSI burst transmitter.
//   burst_state_e : burst FSM states
//   cnt_width()   : counter width for a given number of distinct values (never below 1)
//   DefaultWidth / DefaultN : word size and burst depth used by the OLED sequencer
package spi_burst_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultN     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap,
    StDone
  } burst_state_e;

  // Width needed to hold num_values distinct values; a zero-width counter is widened to 1.
  function automatic int unsigned cnt_width(input int unsigned num_values);
    return (num_values <= 1) ? 1 : $clog2(num_values);
  endfunction

endpackage

// File: rtl/spi_word_serializer.sv
// WIDTH-bit load/shift register that presents one bit of a word per shift.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   load_i   : load data_i into the shift register (wins over shift_i)
//   data_i   : word to load
//   shift_i  : advance to the next bit
//   serial_o : current bit (MSB or LSB end, selected by LSB_FIRST)
module spi_word_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             serial_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= data_i;
    end else if (shift_i) begin
      sr_q <= LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
    end
  end

  assign serial_o = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];

endmodule

// File: rtl/spi_mosi_burst_tx.sv
// SPI MOSI burst transmitter: latches up to N words with per-word D/C flags on a start
// request and shifts them out back-to-back under one chip-select window.
//   i_SCK / i_RST_N : clock, asynchronous active-low reset
//   i_START         : start request, accepted in idle or done
//   i_DATA / i_DC   : words (word 0 first) and their D/C flags
//   i_N_TRANSMIT    : words to send, clamped to N
//   o_MOSI, o_CS, o_DC : serial data, active-low chip select, D/C of current word
//   o_BUSY, o_DONE, o_FINAL_BYTE : burst active, end pulse, last word shifting
// All outputs are registered from the current FSM state, so they lag the state by one cycle.
// Optional feature: define SPI_BURST_CS_TOGGLE_EN to raise o_CS during every inter-word gap
// (a one-cycle gap is forced when GAP_CYCLES is 0).
module spi_mosi_burst_tx
  import spi_burst_pkg::*;
#(
  parameter int unsigned WIDTH      = DefaultWidth,
  parameter int unsigned N          = DefaultN,
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          LSB_FIRST  = 1'b0
) (
  input  logic                   i_SCK,
  input  logic                   i_RST_N,
  input  logic                   i_START,
  input  logic [WIDTH*N-1:0]     i_DATA,
  input  logic [N-1:0]           i_DC,
  input  logic [$clog2(N+1)-1:0] i_N_TRANSMIT,
  output logic                   o_MOSI,
  output logic                   o_CS,
  output logic                   o_DC,
  output logic                   o_BUSY,
  output logic                   o_DONE,
  output logic                   o_FINAL_BYTE
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned BW = cnt_width(WIDTH);
`ifdef SPI_BURST_CS_TOGGLE_EN
  localparam bit          CsToggle = 1'b1;
  localparam int unsigned EffGap   = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
`else
  localparam bit          CsToggle = 1'b0;
  localparam int unsigned EffGap   = GAP_CYCLES;
`endif
  localparam int unsigned GW      = cnt_width(EffGap + 1);
  localparam int unsigned GapLast = (EffGap > 0) ? EffGap - 1 : 0;

  localparam logic [BW-1:0] BitLastC = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GapLastC = GW'(GapLast);
  localparam logic [CW-1:0] NC       = CW'(N);

  burst_state_e       state_q, state_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]      word_idx_q, word_idx_d;
  logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
  logic [CW-1:0]      count_q, count_clamped;
  logic [WIDTH*N-1:0] data_q;
  logic [N-1:0]       dc_flags_q;
  logic               latch;

  logic               ser_load, ser_shift, ser_bit;
  logic [WIDTH-1:0]   ser_word;

  logic [CW-1:0]      next_idx;
  logic               last_word;

  logic mosi_q, cs_q, dc_q, busy_q, done_q, final_q;

  function automatic logic [WIDTH-1:0] word_at(input logic [WIDTH*N-1:0] d,
                                               input logic [CW-1:0]      idx);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == CW'(k)) w = d[k*WIDTH +: WIDTH];
    end
    return w;
  endfunction

  function automatic logic flag_at(input logic [N-1:0] f, input logic [CW-1:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (idx == CW'(k)) b = f[k];
    end
    return b;
  endfunction

  assign count_clamped = (i_N_TRANSMIT > NC) ? NC : i_N_TRANSMIT;
  assign next_idx      = word_idx_q + CW'(1);
  assign last_word     = (next_idx == count_q);

  // Next-state logic: FSM, counters and serializer control.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_idx_d = word_idx_q;
    gap_cnt_d  = gap_cnt_q;
    latch      = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_word   = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (i_START) begin
          latch = 1'b1;
          if (count_clamped == '0) begin
            state_d = StDone;
          end else begin
            state_d    = StShift;
            bit_cnt_d  = '0;
            word_idx_d = '0;
            ser_load   = 1'b1;
            ser_word   = i_DATA[WIDTH-1:0];
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end

      StShift: begin
        if (bit_cnt_q == BitLastC) begin
          bit_cnt_d = '0;
          if (last_word) begin
            state_d = StDone;
          end else if (EffGap > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            // Zero-gap streaming: next word loads on the edge that ends this one.
            word_idx_d = next_idx;
            ser_load   = 1'b1;
            ser_word   = word_at(data_q, next_idx);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          ser_shift = 1'b1;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapLastC) begin
          state_d    = StShift;
          gap_cnt_d  = '0;
          word_idx_d = next_idx;
          ser_load   = 1'b1;
          ser_word   = word_at(data_q, next_idx);
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_SCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      gap_cnt_q  <= '0;
      count_q    <= '0;
      data_q     <= '0;
      dc_flags_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      if (latch) begin
        count_q    <= count_clamped;
        data_q     <= i_DATA;
        dc_flags_q <= i_DC;
      end
    end
  end

  spi_word_serializer #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_serializer (
    .clk_i    (i_SCK),
    .rst_ni   (i_RST_N),
    .load_i   (ser_load),
    .data_i   (ser_word),
    .shift_i  (ser_shift),
    .serial_o (ser_bit)
  );

  // Output registers: a pure function of the current state, one cycle behind it.
  always_ff @(posedge i_SCK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      final_q <= 1'b0;
    end else begin
      mosi_q  <= (state_q == StShift) && ser_bit;
      cs_q    <= !((state_q == StShift) || ((state_q == StGap) && !CsToggle));
      busy_q  <= (state_q == StShift) || (state_q == StGap);
      done_q  <= (state_q == StDone);
      final_q <= (state_q == StShift) && last_word;
      // During a gap word_idx_q still points at the word just sent.
      if ((state_q == StShift) || (state_q == StGap)) begin
        dc_q <= flag_at(dc_flags_q, word_idx_q);
      end
    end
  end

  assign o_MOSI       = mosi_q;
  assign o_CS         = cs_q;
  assign o_DC         = dc_q;
  assign o_BUSY       = busy_q;
  assign o_DONE       = done_q;
  assign o_FINAL_BYTE = final_q;

endmodule
